bitmap_encoder: RTL
===================

# bitmap_encoder

Streaming compressor that turns a dense tile into the bitmap + packed non-zero format consumed by the SIGMA controller. It accepts one dense column of `I_ROW_SIZE` elements per beat, builds the `I_ROW_SIZE x I_COL_SIZE` bitmap, and packs the non-zero values column-major into a buffer. It presents the finished tile with a valid/ready handshake. It sits upstream of the controller's streaming-matrix inputs (`i_valid`, `i_bit_map`, `i_nonzero_ele`).

## Interface
- `I_ROW_SIZE`, 4, rows per tile (elements per input beat)
- `I_COL_SIZE`, 8, columns per tile (beats per tile)
- `LOG2_I_COL_SIZE`, 3, column counter width
- `I_BUFF_SIZE`, 32, packed buffer depth; must equal `I_ROW_SIZE*I_COL_SIZE`
- `LOG2_I_BUFF_SIZE`, 5, buffer index width
- `DATA_TYPE`, 32, element width
- `clk` in 1: single clock, rising edge
- `rst` in 1: **asynchronous, active-high** reset
- `in_valid` in 1: dense column present
- `in_ready` out 1: encoder can accept a column
- `in_col` in `DATA_TYPE` x `I_ROW_SIZE`: dense column, index = row
- `out_valid` out 1: tile complete and held
- `out_ready` in 1: downstream consumes the tile
- `out_bit_map` out 1 x `I_ROW_SIZE` x `I_COL_SIZE`: `[row][col]`, 1 = non-zero
- `out_nonzero_ele` out `DATA_TYPE` x `I_BUFF_SIZE`: packed non-zeros
- `out_nnz` out `LOG2_I_BUFF_SIZE+1`: count of valid entries in `out_nonzero_ele`

## Operation
- Two-state FSM:
  - FILL: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
  - `in_ready` and `out_valid` decode directly from the state register.
- FILL behaviour:
  - Each beat (`in_valid & in_ready`) processes column `col_cnt`.
  - For each row r: `out_bit_map[r][col_cnt] <= (in_col[r] != 0)`.
  - Non-zero elements are written to `out_nonzero_ele[out_nnz + k]`, where k is the number of non-zero rows below r in that beat. Within a column they are packed in ascending row order.
  - `out_nnz += popcount(column)`.
  - `col_cnt` increments.
- FILL → HOLD on the beat where `col_cnt == I_COL_SIZE-1`; `col_cnt` wraps to 0.
- HOLD behaviour:
  - All outputs are frozen.
  - When `out_ready=1`: go to FILL, clear `out_bit_map`, clear `out_nonzero_ele` to 0, clear `out_nnz` to 0.
- Packing is column-major: all of column 0's non-zeros first, then column 1's, and so on. This order matches the per-column non-zero counters in the controller.
- Unused slots `[out_nnz .. I_BUFF_SIZE-1]` read 0.
- `in_valid=0` in FILL: no state change; partial tile is kept.
- `out_ready` in FILL is ignored.
- An all-zero tile still completes, with `out_nnz=0`.
- A fully dense tile gives `out_nnz=I_BUFF_SIZE`; overflow is impossible by construction.

## Timing
- Reset (async assert, sync-safe deassert):
  - State = FILL, `col_cnt=0`.
  - `out_bit_map` all 0, `out_nonzero_ele` all 0, `out_nnz=0`, `out_valid=0`.
  - `in_ready=1` from the first edge after deassert.
- Latency: the last-column beat accepted at edge N gives `out_valid=1` after edge N.
- Throughput: `I_COL_SIZE` beats plus one HOLD cycle minimum per tile. There is one bubble: `in_ready=0` during the cycle `out_ready` is sampled.
- `out_*` are registered and stable while `out_valid & ~out_ready`.
- Reset mid-tile discards the partial tile immediately, with no `out_valid` pulse.

## Configuration
- Macro: `BITMAP_ENC_THRESH_EN`.
- Defined:
  - Adds input port `thresh` (`DATA_TYPE`, unsigned).
  - An element counts as non-zero iff `in_col[r] > thresh`, compared unsigned.
  - Elements at or below `thresh` are dropped (pruning).
- Undefined:
  - No `thresh` port.
  - Non-zero test is `in_col[r] != 0`.

## Structure
- Package `bitmap_pkg`: FSM state enum (`ST_FILL`, `ST_HOLD`) and a localparam for the `out_nnz` width (`LOG2_I_BUFF_SIZE+1`).
- Sub-module `col_compactor`:
  - Combinational.
  - Inputs: one column plus base offset.
  - Outputs: per-row non-zero mask, per-row packed destination index (exclusive prefix popcount + base), and column popcount.
  - The top level holds the FSM, counters and output registers.

## Test plan
- Dense tile, column c row r = `c*4+r+1` → `out_bit_map` all 1, `out_nnz=32`, `out_nonzero_ele[i]=i+1`, `out_valid` one cycle after beat 8.
- All-zero tile → `out_bit_map` all 0, `out_nnz=0`, all `out_nonzero_ele` 0, tile still completes.
- Diagonal pattern, only `in_col[c%4]=c+10` non-zero → `out_bit_map[c%4][c]=1`, `out_nnz=8`, `out_nonzero_ele[c]=c+10`, slots 8..31 = 0.
- Backpressure: hold `out_ready=0` for 5 cycles → outputs stable, `in_ready=0`, extra `in_valid` beats ignored; `out_ready=1` → FILL next cycle, outputs cleared.
- Bubbly `in_valid`, asserted every other cycle → same result as back-to-back.
- Reset asserted after beat 3 → next tile is encoded from column 0 with no leftover bits.
- `BITMAP_ENC_THRESH_EN`, `thresh=5`, values 0..31 → bitmap set only for values 6..31, `out_nnz=26`.

Source files
------------

// File: rtl/bitmap_encoder_pkg.sv
// Shared types and sizes for the bitmap encoder: tile geometry, FSM states
// and the packed container types used on the encoder's bus.
package bitmap_pkg;

  localparam int I_ROW_SIZE       = 4;
  localparam int I_COL_SIZE       = 8;
  localparam int LOG2_I_COL_SIZE  = 3;
  localparam int I_BUFF_SIZE      = 32;
  localparam int LOG2_I_BUFF_SIZE = 5;
  localparam int DATA_TYPE        = 32;

  // out_nnz must be able to hold I_BUFF_SIZE itself (fully dense tile)
  localparam int NNZ_W = LOG2_I_BUFF_SIZE + 1;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef logic [I_ROW_SIZE-1:0][DATA_TYPE-1:0]  col_t;
  typedef logic [I_ROW_SIZE-1:0][I_COL_SIZE-1:0] bit_map_t;
  typedef logic [I_BUFF_SIZE-1:0][DATA_TYPE-1:0] buff_t;
  typedef logic [NNZ_W-1:0]                      nnz_t;

endpackage

// File: rtl/bitmap_encoder_if.sv
// Streaming bus of the bitmap encoder: dense-column input handshake and
// finished-tile output handshake. The encoder uses the slave modport.
interface bitmap_encoder_if;
  import bitmap_pkg::*;

  logic     in_valid;
  logic     in_ready;
  col_t     in_col;
  logic     out_valid;
  logic     out_ready;
  bit_map_t out_bit_map;
  buff_t    out_nonzero_ele;
  nnz_t     out_nnz;

  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_bit_map, out_nonzero_ele, out_nnz
  );

  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, out_bit_map, out_nonzero_ele, out_nnz
  );

endinterface

// File: rtl/bitmap_encoder_col_compactor.sv
// Combinational column compactor: flags the non-zero rows of one dense
// column, gives each a packed destination slot (base + count of non-zero
// rows below it) and returns the column popcount.
// Optional feature: BITMAP_ENC_THRESH_EN turns the non-zero test into an
// unsigned "greater than thresh" test.
module col_compactor
  import bitmap_pkg::*;
(
  input  col_t                    col,
`ifdef BITMAP_ENC_THRESH_EN
  input  logic [DATA_TYPE-1:0]    thresh,
`endif
  input  nnz_t                    base,
  output logic [I_ROW_SIZE-1:0]   mask,
  output nnz_t [I_ROW_SIZE-1:0]   dest,
  output nnz_t                    pop
);

  nnz_t run;

  // Mask, exclusive prefix count and popcount, walking rows bottom-up
  always_comb begin
    run  = {NNZ_W{1'b0}};
    mask = {I_ROW_SIZE{1'b0}};
    dest = {(I_ROW_SIZE*NNZ_W){1'b0}};
    for (int r = 0; r < I_ROW_SIZE; r++) begin
`ifdef BITMAP_ENC_THRESH_EN
      mask[r] = (col[r] > thresh);
`else
      mask[r] = (col[r] != {DATA_TYPE{1'b0}});
`endif
      dest[r] = base + run;
      run     = run + {{(NNZ_W-1){1'b0}}, mask[r]};
    end
    pop = run;
  end

endmodule

// File: rtl/bitmap_encoder.sv
// bitmap_encoder: accepts one dense column per beat, builds the row x col
// bitmap and packs non-zero values column-major, then holds the finished
// tile on a valid/ready handshake until downstream takes it.
// Optional feature: BITMAP_ENC_THRESH_EN adds the 'thresh' pruning port.
module bitmap_encoder
  import bitmap_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
`ifdef BITMAP_ENC_THRESH_EN
  input  logic [DATA_TYPE-1:0] thresh,
`endif
  bitmap_encoder_if.slave      bus
);

  state_t                     state;
  logic [LOG2_I_COL_SIZE-1:0] col_cnt;
  bit_map_t                   bit_map;
  buff_t                      nz_ele;
  nnz_t                       nnz;

  logic [I_ROW_SIZE-1:0]      mask;
  nnz_t [I_ROW_SIZE-1:0]      dest;
  nnz_t                       pop;

  col_compactor u_col_compactor (
    .col    (bus.in_col),
`ifdef BITMAP_ENC_THRESH_EN
    .thresh (thresh),
`endif
    .base   (nnz),
    .mask   (mask),
    .dest   (dest),
    .pop    (pop)
  );

  // Handshake flags decode straight from the state register
  assign bus.in_ready        = (state == ST_FILL);
  assign bus.out_valid       = (state == ST_HOLD);
  assign bus.out_bit_map     = bit_map;
  assign bus.out_nonzero_ele = nz_ele;
  assign bus.out_nnz         = nnz;

  // Tile FSM: fill columns, then hold the tile until out_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FILL;
      col_cnt <= {LOG2_I_COL_SIZE{1'b0}};
      bit_map <= {(I_ROW_SIZE*I_COL_SIZE){1'b0}};
      nz_ele  <= {(I_BUFF_SIZE*DATA_TYPE){1'b0}};
      nnz     <= {NNZ_W{1'b0}};
    end else begin
      case (state)
        ST_FILL: begin
          if (bus.in_valid) begin
            for (int r = 0; r < I_ROW_SIZE; r++) begin
              bit_map[r][col_cnt] <= mask[r];
              // destinations of non-zero rows are always < I_BUFF_SIZE
              if (mask[r]) begin
                nz_ele[dest[r][LOG2_I_BUFF_SIZE-1:0]] <= bus.in_col[r];
              end
            end
            nnz <= nnz + pop;
            if (col_cnt == LOG2_I_COL_SIZE'(I_COL_SIZE - 1)) begin
              col_cnt <= {LOG2_I_COL_SIZE{1'b0}};
              state   <= ST_HOLD;
            end else begin
              col_cnt <= col_cnt + LOG2_I_COL_SIZE'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            bit_map <= {(I_ROW_SIZE*I_COL_SIZE){1'b0}};
            nz_ele  <= {(I_BUFF_SIZE*DATA_TYPE){1'b0}};
            nnz     <= {NNZ_W{1'b0}};
            state   <= ST_FILL;
          end
        end
        default: begin
          state   <= ST_FILL;
          col_cnt <= {LOG2_I_COL_SIZE{1'b0}};
        end
      endcase
    end
  end

endmodule
